// File: rtl/ws2811_decoder.sv
// WS2811 single-wire decoder: measures high/low times of the synchronised line,
// assembles bytes, and flags reset gaps (latch) and line faults (err).
module ws2811_decoder #(
  parameter int unsigned THRESH    = 38,
  parameter int unsigned MIN_HIGH  = 6,
  parameter int unsigned MAX_HIGH  = 60,
  parameter int unsigned RESET_CYC = 3000,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        din,
  output logic [7:0]  data,
  output logic        valid,
  output logic        latch,
  output logic        err,
  output logic [15:0] nbytes
);

  localparam logic [15:0] ThreshC   = 16'(THRESH);
  localparam logic [15:0] MinHighC  = 16'(MIN_HIGH);
  localparam logic [15:0] MaxHighC  = 16'(MAX_HIGH);
  localparam logic [15:0] ResetCycC = 16'(RESET_CYC);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StStuck} state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, dly_q;
  logic        rise_q, rise_d, fall_q, fall_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d, shift_new;
  logic [7:0]  data_q, data_d;
  logic [15:0] nbytes_q, nbytes_d, nbytes_inc;
  logic        valid_q, valid_d, latch_q, latch_d, err_q, err_d;
  logic        bit_val;

  // Edges are registered so the FSM sees a clean one-cycle pulse per transition.
  always_comb begin
    rise_d = sync2_q & ~dly_q;
    fall_d = ~sync2_q & dly_q;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      nbytes_q <= '0;
      valid_q  <= 1'b0;
      latch_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
      valid_q  <= valid_d;
      latch_q  <= latch_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    nbytes_inc = (nbytes_q == 16'hFFFF) ? nbytes_q : nbytes_q + 16'd1;
    bit_val    = (cnt_q >= ThreshC);
    shift_new  = MSB_FIRST ? {shift_q[6:0], bit_val} : {bit_val, shift_q[7:1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    nbytes_d = nbytes_q;
    valid_d  = 1'b0;
    latch_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise_q) begin
          state_d = StHigh;
          cnt_d   = 16'd1;
        end
      end
      StHigh: begin
        if (fall_q) begin
          state_d = StLow;
          cnt_d   = 16'd1;
          if (cnt_q < MinHighC) begin
            err_d = 1'b1;  // glitch: drop the pulse, partial byte survives
          end else begin
            shift_d = shift_new;
            if (bitcnt_q == 3'd7) begin
              bitcnt_d = '0;
              data_d   = shift_new;
              valid_d  = 1'b1;
              nbytes_d = nbytes_inc;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end else if (cnt_inc > MaxHighC) begin
          err_d    = 1'b1;
          bitcnt_d = '0;
          state_d  = StStuck;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StStuck: begin
        if (fall_q) begin
          state_d  = StLow;
          cnt_d    = 16'd1;
          bitcnt_d = '0;
        end
      end
      StLow: begin
        if (rise_q) begin
          state_d = StHigh;
          cnt_d   = 16'd1;
        end else if (cnt_inc >= ResetCycC) begin
          latch_d  = 1'b1;
          err_d    = (bitcnt_q != 3'd0);
          nbytes_d = '0;
          bitcnt_d = '0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign latch  = latch_q;
  assign err    = err_q;
  assign nbytes = nbytes_q;

endmodule
